// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
//   state_e    : loader FSM encoding (3 bits)
//   WORD_BYTES : bytes per instruction word
//   LEN_BYTES  : bytes in the big-endian word-count header
package imem_loader_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned LEN_BYTES  = 2;

    typedef enum logic [2:0] {
        StLenHi = 3'd0,
        StLenLo = 3'd1,
        StData  = 3'd2,
        StCheck = 3'd3,
        StDone  = 3'd4,
        StErr   = 3'd5
    } state_e;

endpackage

// File: rtl/imem_loader_byte_word_packer.sv
// Big-endian byte-to-word packer: shifts bytes in MSB first and raises
// word_valid for one cycle, the cycle after the last byte of a word.
// Ports:
//   clk, reset  : clock, synchronous active-high reset (clears partial word)
//   byte_data   : incoming byte
//   byte_valid  : shift byte_data in this cycle
//   last_byte   : the next accepted byte completes a word
//   word_valid  : registered one-cycle strobe, word holds the full word
//   word        : shift register contents
module byte_word_packer
    import imem_loader_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              byte_data,
    input  logic                    byte_valid,
    output logic                    last_byte,
    output logic                    word_valid,
    output logic [8*WORD_BYTES-1:0] word
);

    localparam int unsigned CntW = $clog2(WORD_BYTES);

    logic [CntW-1:0]         cnt_q;
    logic [8*WORD_BYTES-1:0] shift_q;
    logic                    valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= byte_valid && last_byte;
            if (byte_valid) begin
                shift_q <= {shift_q[8*WORD_BYTES-9:0], byte_data};
                cnt_q   <= cnt_q + CntW'(1);
            end
        end
    end

    assign last_byte  = (cnt_q == CntW'(WORD_BYTES - 1));
    assign word_valid = valid_q;
    assign word       = shift_q;

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a byte stream (16-bit big-endian word
// count, 4*N data bytes, optional XOR checksum byte), writes each assembled
// big-endian word to consecutive word addresses and holds the core in reset
// until the image is loaded.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (trailing checksum byte
// and CHECK state). Undefined: the last data byte goes straight to DONE.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   in_data/valid/ready   : byte stream handshake
//   imem_we/addr/wdata    : instruction memory write port
//   cpu_reset             : core reset, low only once DONE
//   done, error           : terminal status
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_reset,
    output logic        done,
    output logic        error
);

    // Header count is 16 bits, so only the low 16 bits of the limit matter.
    localparam logic [15:0] MaxWords = 16'(MAX_WORDS);

    state_e      state_q, state_d;
    logic [7:0]  len_hi_q;
    logic [15:0] len_q;
    logic [15:0] word_cnt_q;
    logic [31:0] addr_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  csum_q;
`endif

    logic        accept;
    logic        data_byte;
    logic        last_byte;
    logic        word_valid;
    logic [31:0] word;
    logic [15:0] hdr_len;

    assign accept    = in_valid && in_ready;
    assign data_byte = accept && (state_q == StData);
    assign hdr_len   = {len_hi_q, in_data};

    byte_word_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .byte_data  (in_data),
        .byte_valid (data_byte),
        .last_byte  (last_byte),
        .word_valid (word_valid),
        .word       (word)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StLenHi: begin
                if (accept) state_d = StLenLo;
            end
            StLenLo: begin
                if (accept) begin
                    if (hdr_len > MaxWords) begin
                        state_d = StErr;
                    end else if (hdr_len == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = StCheck;
`else
                        state_d = StDone;
`endif
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (data_byte && last_byte && (16'(word_cnt_q + 16'd1) == len_q)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = StCheck;
`else
                    state_d = StDone;
`endif
                end
            end
            StCheck: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (accept) state_d = (in_data == csum_q) ? StDone : StErr;
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StLenHi;
            len_hi_q   <= '0;
            len_q      <= '0;
            word_cnt_q <= '0;
            addr_q     <= BASE_ADDR;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (accept && (state_q == StLenHi)) len_hi_q <= in_data;
            if (accept && (state_q == StLenLo)) len_q <= hdr_len;
            if (data_byte && last_byte) word_cnt_q <= word_cnt_q + 16'd1;
            // Address advances after each write so it always names the current word.
            if (word_valid) addr_q <= addr_q + 32'd4;
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (data_byte) csum_q <= csum_q ^ in_data;
`endif
        end
    end

    assign in_ready   = (state_q != StDone) && (state_q != StErr);
    assign imem_we    = word_valid;
    assign imem_addr  = addr_q;
    assign imem_wdata = word;
    assign done       = (state_q == StDone);
    assign error      = (state_q == StErr);
    assign cpu_reset  = (state_q != StDone);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader; adapts to IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset;
    logic        done;
    logic        error;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] wr_addr [8];
    logic [31:0] wr_data [8];
    int          n_wr;

    always #5 clk = ~clk;

    imem_loader #(
        .BASE_ADDR (32'h0000_0000),
        .MAX_WORDS (256)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .error      (error)
    );

    // Write log, sampled mid-cycle.
    always @(negedge clk) begin
        if (imem_we) begin
            if (n_wr < 8) begin
                wr_addr[n_wr] = imem_addr;
                wr_data[n_wr] = imem_wdata;
            end
            n_wr = n_wr + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        in_data  = 8'h00;
        reset    = 1'b1;
        idle(2);
        reset = 1'b0;
        n_wr  = 0;
    endtask

    initial begin
        n_wr = 0;
        do_reset();

        // Reset state
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_wdata", imem_wdata, 32'h0);
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);

        // Two words at full rate. Byte XOR: 20^08^00^05^AC^08^00^00 = 89.
        send(8'h00); send(8'h02);
        send(8'h20); send(8'h08); send(8'h00); send(8'h05);
        send(8'hAC); send(8'h08); send(8'h00); send(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check("t1_done_before_csum", 32'(done), 32'd0);
        send(8'h89);
`else
        check("t1_we_with_done", 32'(imem_we), 32'd1);
`endif
        check("t1_done", 32'(done), 32'd1);
        check("t1_cpu_reset", 32'(cpu_reset), 32'd0);
        check("t1_in_ready", 32'(in_ready), 32'd0);
        idle(3);
        check("t1_n_wr", 32'(n_wr), 32'd2);
        check("t1_addr0", wr_addr[0], 32'h0);
        check("t1_data0", wr_data[0], 32'h2008_0005);
        check("t1_addr1", wr_addr[1], 32'h4);
        check("t1_data1", wr_data[1], 32'hAC08_0000);
        // DONE is terminal: further bytes are ignored.
        in_data  = 8'h55;
        in_valid = 1'b1;
        idle(5);
        in_valid = 1'b0;
        check("t1_no_more_wr", 32'(n_wr), 32'd2);
        check("t1_done_held", 32'(done), 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Wrong checksum
        do_reset();
        send(8'h00); send(8'h02);
        send(8'h20); send(8'h08); send(8'h00); send(8'h05);
        send(8'hAC); send(8'h08); send(8'h00); send(8'h00);
        send(8'h8D);
        check("t2_error", 32'(error), 32'd1);
        check("t2_done", 32'(done), 32'd0);
        check("t2_cpu_reset", 32'(cpu_reset), 32'd1);
        idle(2);
        check("t2_n_wr", 32'(n_wr), 32'd2);
`endif

        // Oversized header: N = 257
        do_reset();
        send(8'h01); send(8'h01);
        check("t3_error", 32'(error), 32'd1);
        check("t3_cpu_reset", 32'(cpu_reset), 32'd1);
        check("t3_in_ready", 32'(in_ready), 32'd0);
        in_data  = 8'h12;
        in_valid = 1'b1;
        idle(6);
        in_valid = 1'b0;
        check("t3_n_wr", 32'(n_wr), 32'd0);
        check("t3_error_held", 32'(error), 32'd1);

        // Empty image
        do_reset();
        send(8'h00); send(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check("t4_done_early", 32'(done), 32'd0);
        send(8'h00);
`endif
        check("t4_done", 32'(done), 32'd1);
        idle(2);
        check("t4_n_wr", 32'(n_wr), 32'd0);

        // One word with in_valid toggling. Byte XOR = 2D.
        do_reset();
        send(8'h00); idle(1);
        send(8'h01); idle(1);
        send(8'h20); idle(1);
        send(8'h08); idle(1);
        send(8'h00); idle(1);
        check("t5_gap_ready", 32'(in_ready), 32'd1);
        check("t5_gap_done", 32'(done), 32'd0);
        send(8'h05); idle(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(8'h2D);
`endif
        idle(2);
        check("t5_done", 32'(done), 32'd1);
        check("t5_n_wr", 32'(n_wr), 32'd1);
        check("t5_addr", wr_addr[0], 32'h0);
        check("t5_data", wr_data[0], 32'h2008_0005);

        // Reset mid-word, then a fresh image. Byte XOR: 11^22^33^44 = 44.
        do_reset();
        send(8'h00); send(8'h01);
        send(8'hAA); send(8'hBB);
        do_reset();
        send(8'h00); send(8'h01);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(8'h44);
`endif
        idle(2);
        check("t6_done", 32'(done), 32'd1);
        check("t6_error", 32'(error), 32'd0);
        check("t6_n_wr", 32'(n_wr), 32'd1);
        check("t6_addr", wr_addr[0], 32'h0);
        check("t6_data", wr_data[0], 32'h1122_3344);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
